usb_crc16: RTL and testbench
============================

// Module: usb_crc16
// PURPOSE
//  Byte-serial USB CRC16 generator/checker for DATA packet payloads. Folds one
//  8-bit byte per enabled clock into a running CRC-16/USB (poly x^16+x^15+x^2+1,
//  reflected). Sits beside the USB packet encoder/decoder. The encoder appends
//  crc_out to DATA payloads. The decoder compares crc_out against the fixed residual.
// PARAMETERS
//  none. Polynomial, init and output inversion are fixed by the USB 2.0 spec.
// PORTS
//  clk      in   1   system clock; all state changes on rising edge
//  n_rst    in   1   reset, synchronous, active-low
//  data_in  in   8   payload byte; bit 0 = first bit on the wire
//  crc_en   in   1   1 = fold data_in into CRC this cycle; 0 = hold
//  crc_out  out  16  ~crc_reg; transmit low byte first, each byte LSB first
// BEHAVIOUR
//  - Clocking: one clock, one reset. Reset is synchronous and active-low:
//    n_rst is sampled only on the rising edge of clk.
//  - State: 16-bit crc_reg. This is the only storage. crc_out = ~crc_reg, continuously.
//  - Reset: on a clk edge with n_rst=0, crc_reg <= 16'hFFFF, so crc_out = 16'h0000.
//    Reset has priority over crc_en, including in the middle of a packet.
//  - Update: on a clk edge with n_rst=1 and crc_en=1, crc_reg <= F(crc_reg, data_in).
//    F applies 8 bit-steps in one cycle. The bit-steps run for i = 0..7, in that order:
//      fb = crc_reg[0] ^ data_in[i];  crc_reg = crc_reg >> 1;
//      if (fb) crc_reg = crc_reg ^ 16'hA001;
//    16'hA001 is 0x8005 bit-reversed.
//    Implement F as a flat combinational XOR network or an unrolled loop. No iterating FSM.
//  - Hold: crc_en=0 leaves crc_reg unchanged. data_in is then don't-care.
//  - Latency: crc_out reflects byte N on the first clk edge after byte N is
//    presented with crc_en=1. Sustains one byte per cycle with no bubbles.
//  - Restart: no clear port. Assert n_rst low for one cycle between packets to re-seed.
//  - Check mode: feed the payload, then the two received CRC bytes (low byte first).
//    If the packet is error-free, crc_reg = 16'hB001, so crc_out = 16'h4FFE.
//  - No X propagation: after the first reset cycle, crc_out is always a known value.
//  - Outputs are registered-state derived only. No combinational path from data_in to crc_out.
// TESTING
//  1. n_rst=0 for 1 edge -> crc_out=16'h0000. Then crc_en=0 for 5 edges -> still 16'h0000.
//  2. Reset, then byte 8'h00 with crc_en=1 for 1 edge -> crc_out=16'hBF40.
//  3. Reset, then ASCII "123456789" (8'h31..8'h39) on 9 consecutive edges -> crc_out=16'hB4C8.
//  4. Same as 3, plus bytes 8'hC8 then 8'hB4 -> crc_out=16'h4FFE (good-packet residual).
//     Flip one payload bit -> crc_out != 16'h4FFE.
//  5. Same as 3, with crc_en=0 cycles inserted between bytes (data_in randomized
//     while idle) -> still 16'hB4C8.
//  6. Mid-stream n_rst=0 with crc_en=1 -> crc_out=16'h0000 next edge. The next
//     byte 8'h00 -> crc_out=16'hBF40.

Source files
------------

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - byte-serial CRC-16/USB generator and checker for DATA payloads
module usb_crc16 (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [7:0]  data_in,
   input  logic        crc_en,
   output logic [15:0] crc_out
);

   // Reflected form of x^16+x^15+x^2+1 (0x8005 bit-reversed).
   localparam logic [15:0] POLY_REFL = 16'hA001;
   localparam logic [15:0] CRC_SEED  = 16'hFFFF;

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic [15:0] crc_fold;

   // Eight wire-order bit steps, unrolled into one flat XOR network.
   // Bit 0 of the byte is the first bit on the wire, so it is folded first.
   function automatic logic [15:0] fold_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ data[i];
         c  = {1'b0, c[15:1]} ^ (fb ? POLY_REFL : 16'h0000);
      end
      return c;
   endfunction

   // Next-state select: fold the presented byte when enabled, otherwise hold.
   always_comb begin
      crc_fold = fold_byte(crc_q, data_in);
      crc_d    = crc_q;
      if (crc_en) begin
         crc_d = crc_fold;
      end
   end

   // CRC register; reset re-seeds and overrides any byte presented on the same edge.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         crc_q <= CRC_SEED;
      end else begin
         crc_q <= crc_d;
      end
   end

   // Output is the ones' complement of the register only, never of data_in.
   assign crc_out = ~crc_q;

endmodule

// File: tb/tb_usb_crc16.sv
// tb/tb_usb_crc16.sv - self-checking bench for usb_crc16
module tb_usb_crc16;

   logic        clk;
   logic        n_rst;
   logic [7:0]  data_in;
   logic        crc_en;
   logic [15:0] crc_out;

   int n_checks;
   int n_fail;

   usb_crc16 dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .data_in (data_in),
      .crc_en  (crc_en),
      .crc_out (crc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: CRC-16/USB as polynomial division over the packet's wire-order bit
   // stream, in the non-reflected MSB-first form with 0x8005, init all ones, and the
   // remainder bit-reversed and inverted at the end.
   function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
      logic [15:0] r;
      logic        bits[$];
      logic [15:0] out;
      foreach (msg[k]) begin
         for (int b = 0; b < 8; b++) bits.push_back(msg[k][b]);
      end
      r = 16'hFFFF;
      foreach (bits[k]) begin
         if (r[15] ^ bits[k]) r = (r << 1) ^ 16'h8005;
         else                 r = r << 1;
      end
      for (int b = 0; b < 16; b++) out[b] = r[15-b];
      return ~out;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst   = 1'b0;
      crc_en  = 1'($urandom);
      data_in = 8'($urandom);
      tick();
      n_rst   = 1'b1;
      crc_en  = 1'b0;
      data_in = 8'($urandom);
   endtask

   task automatic feed(input logic [7:0] b);
      data_in = b;
      crc_en  = 1'b1;
      tick();
      crc_en  = 1'b0;
      data_in = 8'($urandom);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (crc_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_value: got %h expected %h", crc_out, 16'h0000);
      end
      for (int i = 0; i < 5; i++) begin
         data_in = 8'($urandom);
         tick();
         n_checks++;
         if (crc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: got %h expected %h", i, crc_out, 16'h0000);
         end
      end
   endtask

   task automatic test_single_zero();
      do_reset();
      feed(8'h00);
      n_checks++;
      if (crc_out !== 16'hBF40) begin
         n_fail++;
         $display("FAIL single_zero: got %h expected %h", crc_out, 16'hBF40);
      end
   endtask

   task automatic test_check_string();
      do_reset();
      for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
      n_checks++;
      if (crc_out !== 16'hB4C8) begin
         n_fail++;
         $display("FAIL check_string: got %h expected %h", crc_out, 16'hB4C8);
      end
   endtask

   task automatic test_residual();
      logic [7:0] msg[$];
      logic [15:0] exp_v;
      int pos;
      do_reset();
      for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
      feed(8'hC8);
      feed(8'hB4);
      n_checks++;
      if (crc_out !== 16'h4FFE) begin
         n_fail++;
         $display("FAIL good_residual: got %h expected %h", crc_out, 16'h4FFE);
      end
      // Corrupt one payload bit; residual must no longer match.
      pos = $urandom_range(0, 71);
      for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
      msg[pos/8][pos%8] = ~msg[pos/8][pos%8];
      msg.push_back(8'hC8);
      msg.push_back(8'hB4);
      exp_v = ref_crc(msg);
      do_reset();
      foreach (msg[k]) feed(msg[k]);
      n_checks++;
      if (crc_out === 16'h4FFE || crc_out !== exp_v) begin
         n_fail++;
         $display("FAIL bad_residual bit %0d: got %h expected %h (not 4ffe)", pos, crc_out, exp_v);
      end
   endtask

   task automatic test_gaps();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         feed(8'h31 + 8'(i));
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            data_in = 8'($urandom);
            tick();
         end
      end
      n_checks++;
      if (crc_out !== 16'hB4C8) begin
         n_fail++;
         $display("FAIL gaps: got %h expected %h", crc_out, 16'hB4C8);
      end
   endtask

   task automatic test_midstream_reset();
      do_reset();
      for (int i = 0; i < 4; i++) feed(8'($urandom));
      n_rst   = 1'b0;
      crc_en  = 1'b1;
      data_in = 8'($urandom);
      tick();
      n_rst   = 1'b1;
      crc_en  = 1'b0;
      n_checks++;
      if (crc_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL midstream_reset: got %h expected %h", crc_out, 16'h0000);
      end
      feed(8'h00);
      n_checks++;
      if (crc_out !== 16'hBF40) begin
         n_fail++;
         $display("FAIL after_midstream_reset: got %h expected %h", crc_out, 16'hBF40);
      end
   endtask

   task automatic test_random_packets();
      logic [7:0] msg[$];
      logic [15:0] exp_v;
      for (int p = 0; p < 8; p++) begin
         msg.delete();
         do_reset();
         for (int i = $urandom_range(1, 16); i > 0; i--) begin
            msg.push_back(8'($urandom));
            feed(msg[$]);
            exp_v = ref_crc(msg);
            n_checks++;
            if (crc_out !== exp_v) begin
               n_fail++;
               $display("FAIL random_pkt%0d byte%0d: got %h expected %h", p, msg.size(), crc_out, exp_v);
            end
         end
         exp_v = ref_crc(msg);
         feed(exp_v[7:0]);
         feed(exp_v[15:8]);
         n_checks++;
         if (crc_out !== 16'h4FFE) begin
            n_fail++;
            $display("FAIL random_pkt%0d residual: got %h expected %h", p, crc_out, 16'h4FFE);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg[$];
      logic [15:0] exp_v;
      for (int p = 0; p < 4; p++) begin
         msg.delete();
         n_rst   = 1'b0;
         crc_en  = 1'b1;
         data_in = 8'($urandom);
         tick();
         n_rst   = 1'b1;
         for (int i = 0; i < 6; i++) begin
            msg.push_back(8'($urandom));
            data_in = msg[$];
            crc_en  = 1'b1;
            tick();
         end
         crc_en = 1'b0;
         exp_v  = ref_crc(msg);
         n_checks++;
         if (crc_out !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back pkt%0d: got %h expected %h", p, crc_out, exp_v);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_rst    = 1'b1;
      crc_en   = 1'b0;
      data_in  = 8'h00;
      tick();
      test_reset();
      test_single_zero();
      test_check_string();
      test_residual();
      test_gaps();
      test_midstream_reset();
      test_random_packets();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
